// File: rtl/branch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// branch_ctrl_pkg
// Shared types for the branch recovery controller:
//   PC_W_DEF     default PC/address width
//   br_state_e   recovery FSM states (IDLE, FLUSH)
//   upd_entry_t  predictor training entry {pc, taken} at the default PC width
// -----------------------------------------------------------------------------
package branch_ctrl_pkg;

  localparam int unsigned PC_W_DEF = 22;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } br_state_e;

  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic                taken;
  } upd_entry_t;

endpackage

// File: rtl/br_update_fifo.sv
// -----------------------------------------------------------------------------
// br_update_fifo
// Synchronous FIFO holding predictor training updates.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   push_i, data_i     write request and data
//   pop_i              read request (head is consumed at the edge)
//   data_o             head entry (valid while empty_o = 0)
//   full_o, empty_o    occupancy flags from registered state
//   count_o            number of stored entries
// A push while full is only taken when a pop happens at the same edge, in
// which case the freed slot is the one being written.
// -----------------------------------------------------------------------------
module br_update_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 23,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/branch_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// branch_recovery_ctrl
// Resolves branches from the ALU stage: on a mispredict it issues a one-cycle
// fetch redirect and a FLUSH_CYCLES-long flush; every accepted branch is queued
// as a training update for the branch predictor.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | accepting resolved branches from the ALU stage
// FLUSH | killing younger stages; ALU branches are wrong-path and ignored
//
// Ports:
//   i_Clk, i_Reset               clock, asynchronous active-high reset
//   i_ALU_isbranch/pc/target     resolving branch and its taken-target
//   i_ALU_outcome/prediction     actual and predicted direction (1 = taken)
//   i_bp_ready                   predictor accepts an update this cycle
//   o_bp_update_valid/pc/taken   head of the training-update queue
//   o_flush                      kill younger pipeline stages
//   o_redirect_valid/pc          one-cycle corrected fetch redirect
//   o_stall                      update queue full
// Optional build macro BRANCH_RECOVERY_STATS_EN adds saturating 16-bit
// counters o_br_count, o_mispred_count, o_drop_count.
// -----------------------------------------------------------------------------
module branch_recovery_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned PC_W         = PC_W_DEF,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned UPD_DEPTH    = 4
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  input  logic            i_ALU_isbranch,
  input  logic [PC_W-1:0] i_ALU_pc,
  input  logic [PC_W-1:0] i_ALU_target,
  input  logic            i_ALU_outcome,
  input  logic            i_ALU_prediction,
  input  logic            i_bp_ready,
  output logic            o_bp_update_valid,
  output logic [PC_W-1:0] o_bp_update_pc,
  output logic            o_bp_update_taken,
  output logic            o_flush,
  output logic            o_redirect_valid,
  output logic [PC_W-1:0] o_redirect_pc,
`ifdef BRANCH_RECOVERY_STATS_EN
  output logic [15:0]     o_br_count,
  output logic [15:0]     o_mispred_count,
  output logic [15:0]     o_drop_count,
`endif
  output logic            o_stall
);

  localparam int unsigned CNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned UCNT_W = $clog2(UPD_DEPTH + 1);

  br_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            redir_valid_q, redir_valid_d;
  logic [PC_W-1:0] redir_pc_q, redir_pc_d;

  logic            accept;
  logic            mispredict;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [UCNT_W-1:0] fifo_count;
  logic [PC_W:0]   fifo_head;

  assign mispredict = (i_ALU_outcome != i_ALU_prediction);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    accept        = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_ALU_isbranch) begin
          accept = 1'b1;
          if (mispredict) begin
            state_d       = FLUSH;
            cnt_d         = CNT_W'(FLUSH_CYCLES - 1);
            redir_valid_d = 1'b1;
            // Not-taken fall-through wraps at the top of the PC space.
            redir_pc_d    = i_ALU_outcome ? i_ALU_target : (i_ALU_pc + PC_W'(1));
          end
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign o_flush          = (state_q == FLUSH);
  assign o_redirect_valid = redir_valid_q;
  assign o_redirect_pc    = redir_pc_q;

  // Pop and push at the same edge are both honoured even when full.
  assign fifo_pop  = !fifo_empty && i_bp_ready;
  assign fifo_push = accept && (!fifo_full || fifo_pop);

  br_update_fifo #(
    .DEPTH (UPD_DEPTH),
    .WIDTH (PC_W + 1)
  ) u_upd_fifo (
    .clk_i   (i_Clk),
    .rst_i   (i_Reset),
    .push_i  (fifo_push),
    .data_i  ({i_ALU_pc, i_ALU_outcome}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign o_bp_update_valid = !fifo_empty;
  assign o_bp_update_pc    = fifo_head[PC_W:1];
  assign o_bp_update_taken = fifo_head[0];
  assign o_stall           = (fifo_count == UCNT_W'(UPD_DEPTH));

`ifdef BRANCH_RECOVERY_STATS_EN
  logic [15:0] br_cnt_q;
  logic [15:0] mis_cnt_q;
  logic [15:0] drop_cnt_q;
  logic        drop;

  assign drop = accept && !fifo_push;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      br_cnt_q   <= '0;
      mis_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (accept && (br_cnt_q != 16'hFFFF)) begin
        br_cnt_q <= br_cnt_q + 16'd1;
      end
      if (accept && mispredict && (mis_cnt_q != 16'hFFFF)) begin
        mis_cnt_q <= mis_cnt_q + 16'd1;
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign o_br_count      = br_cnt_q;
  assign o_mispred_count = mis_cnt_q;
  assign o_drop_count    = drop_cnt_q;
`endif

endmodule
